// File: rtl/mips_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type function codes, ALU control codes and the ALU-op selector.
package mips_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// Maps the controller's ALU-op selector and the R-type funct field to the
// 3-bit ALU control code; unknown functs fall back to add.
module alu_decoder
  import mips_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucont = ALU_ADD;
          FUNCT_SUB: alucont = ALU_SUB;
          FUNCT_AND: alucont = ALU_AND;
          FUNCT_OR:  alucont = ALU_OR;
          FUNCT_SLT: alucont = ALU_SLT;
          default:   alucont = ALU_ADD;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control unit: Moore FSM whose state register is the only
// storage; every datapath control is decoded combinationally from state and zero.
module mips_controller
  import mips_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [3:0] irwrite,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_state;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_regwrite;
  logic [3:0] w_irwrite;
  logic [1:0] w_aluop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH1;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH1;
    case (r_state)
      S_FETCH1: w_next = S_FETCH2;
      S_FETCH2: w_next = S_FETCH3;
      S_FETCH3: w_next = S_FETCH4;
      S_FETCH4: w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_J:         w_next = S_JEX;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH1;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LB) ? S_LBRD : S_SBWR;
      S_LBRD:    w_next = S_LBWR;
      S_RTYPEEX: w_next = S_RTYPEWR;
      S_ADDIEX:  w_next = S_ADDIWR;
      default:   w_next = S_FETCH1;
    endcase
  end

  // While reset is held the outputs show FETCH1, independent of the stale state.
  assign w_state = reset ? S_FETCH1 : r_state;

  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_irwrite  = '0;
    w_aluop    = ALUOP_ADD;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsource   = 2'b00;
    case (w_state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        w_irwrite = 4'b0001 << w_state[1:0];
        alusrcb   = 2'b01;
        w_pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_LBRD: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        iord    = 1'b1;
      end
      S_SBWR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_LBWR: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        alusrca    = 1'b1;
        w_aluop    = ALUOP_FUNCT;
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsource = 2'b01;
        w_branch = 1'b1;
      end
      S_JEX: begin
        pcsource  = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign irwrite  = reset ? 4'b0000 : w_irwrite;

  alu_decoder u_alu_decoder (
    .aluop   (w_aluop),
    .funct   (funct),
    .alucont (alucont)
  );

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: a driver pushes the per-cycle expected
// control word from an instruction-level model; a monitor compares on negedge.
module tb_mips_controller;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [3:0] irwrite;
    logic [1:0] alusrcb;
    logic [2:0] alucont;
    logic [1:0] pcsource;
  } ctl_t;

  typedef struct {
    ctl_t       v;
    logic [5:0] op;
    int         step;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       pcen, iord, memwrite, regdst, memtoreg, regwrite, alusrca;
  logic [3:0] irwrite;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucont;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .irwrite(irwrite), .alusrcb(alusrcb), .alucont(alucont), .pcsource(pcsource)
  );

  // Instruction length in cycles, counting FETCH1 through the last state.
  function automatic int instr_len(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000, 6'b000000, 6'b001000: return 7;
      6'b000100, 6'b000010: return 6;
      default: return 5;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic ctl_t reset_ctl();
    ctl_t c = '0;
    c.alusrcb = 2'b01;
    c.alucont = 3'b010;
    return c;
  endfunction

  // Expected controls for step idx of an instruction (idx 0 = FETCH1).
  function automatic ctl_t model(input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input int idx);
    ctl_t c = '0;
    c.alucont = 3'b010;
    if (idx < 4) begin
      c.irwrite = 4'(1 << idx);
      c.alusrcb = 2'b01;
      c.pcen    = 1'b1;
    end else if (idx == 4) begin
      c.alusrcb = 2'b11;
    end else begin
      case (o)
        6'b100000: begin
          if (idx == 7) begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
          end else begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.iord    = (idx == 6);
          end
        end
        6'b101000: begin
          c.alusrca  = 1'b1;
          c.alusrcb  = 2'b10;
          c.iord     = (idx == 6);
          c.memwrite = (idx == 6);
        end
        6'b000000: begin
          c.alusrca  = 1'b1;
          c.alucont  = funct_alu(f);
          c.regwrite = (idx == 6);
          c.regdst   = (idx == 6);
        end
        6'b001000: begin
          c.alusrca  = 1'b1;
          c.alusrcb  = 2'b10;
          c.regwrite = (idx == 6);
        end
        6'b000100: begin
          c.alusrca  = 1'b1;
          c.alucont  = 3'b110;
          c.pcsource = 2'b01;
          c.pcen     = z;
        end
        6'b000010: begin
          c.pcsource = 2'b10;
          c.pcen     = 1'b1;
        end
        default: ;
      endcase
    end
    return c;
  endfunction

  task automatic drive_reset_cycle();
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    zero  = 1'($urandom_range(1));
    e.v = reset_ctl(); e.op = op; e.step = -1;
    q.push_back(e);
  endtask

  // zmode: 0 -> zero low, 1 -> zero high, 2 -> random each cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input int abort_at);
    exp_t e;
    int   n = instr_len(o);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        drive_reset_cycle();
        return;
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      op    = o;
      funct = f;
      zero  = (zmode == 2) ? 1'($urandom_range(1)) : (zmode == 1);
      e.v = model(o, f, zero, i); e.op = o; e.step = i;
      q.push_back(e);
    end
  endtask

  initial begin : monitor
    ctl_t act;
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = '{pcen, iord, memwrite, regdst, memtoreg, regwrite, alusrca,
                irwrite, alusrcb, alucont, pcsource};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL ctl op=%b step=%0d actual=%b required=%b @%0t",
                   e.op, e.step, act, e.v, $time);
        end
      end
    end
  end

  initial begin : driver
    logic [5:0] ops[7] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100,
                           6'b000010, 6'b001000, 6'b111111};
    logic [5:0] fns[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b000111, 6'b111111};
    logic [5:0] o, f;
    int         ab;

    drive_reset_cycle();
    drive_reset_cycle();
    run_instr(6'b000000, 6'b100101, 2, -1);
    run_instr(6'b100000, 6'b000000, 2, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b101000, 6'b000000, 2, -1);
    run_instr(6'b000010, 6'b000000, 2, -1);
    run_instr(6'b111111, 6'b000000, 2, -1);
    run_instr(6'b101000, 6'b000000, 2, 6);
    run_instr(6'b000000, 6'b000111, 2, -1);
    run_instr(6'b001000, 6'b000000, 2, -1);
    for (int k = 0; k < 5; k++) run_instr(6'b000000, fns[k], 2, -1);

    for (int k = 0; k < 250; k++) begin
      o = ($urandom_range(7) == 0) ? 6'($urandom) : ops[$urandom_range(6)];
      f = ($urandom_range(5) == 0) ? 6'($urandom) : fns[$urandom_range(6)];
      ab = ($urandom_range(15) == 0) ? int'($urandom_range(instr_len(o) - 1)) : -1;
      run_instr(o, f, 2, ab);
    end
    run_instr(6'b000010, 6'b000000, 2, -1);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_controller.md
MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: op  input  6  opcode; funct  input  6  R-type function field; zero  input  1  ALU zero flag.
REQ-005 SHALL have ports: pcen, iord, memwrite, regdst, memtoreg, regwrite, alusrca  output  1 each  datapath controls.
REQ-006 SHALL have ports: irwrite  output  4  one-hot IR byte enable; alusrcb  output  2; alucont  output  3; pcsource  output  2.

Function
REQ-007 SHALL implement a multicycle Moore FSM with states FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR.
REQ-008 SHALL sequence FETCH1->FETCH2->FETCH3->FETCH4->DECODE unconditionally.
REQ-009 SHALL branch from DECODE on op: 100000 lb / 101000 sb -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 000010 -> JEX; 001000 -> ADDIEX; any other op -> FETCH1.
REQ-010 SHALL go MEMADR->LBRD (lb) or SBWR (sb); LBRD->LBWR; RTYPEEX->RTYPEWR; ADDIEX->ADDIWR; LBWR, SBWR, RTYPEWR, ADDIWR, BEQEX, JEX -> FETCH1.
REQ-011 FETCHn SHALL drive irwrite = 1<<(n-1), iord 0, alusrca 0, alusrcb 01, alucont add, pcsource 00, pcwrite 1.
REQ-012 DECODE SHALL drive alusrca 0, alusrcb 11, alucont add; no write enables.
REQ-013 MEMADR, LBRD, SBWR SHALL drive alusrca 1, alusrcb 10, alucont add; LBRD and SBWR add iord 1; SBWR adds memwrite 1.
REQ-014 LBWR SHALL drive regwrite 1, memtoreg 1, regdst 0.
REQ-015 RTYPEEX and RTYPEWR SHALL drive alusrca 1, alusrcb 00, alucont from funct; RTYPEWR adds regwrite 1, regdst 1, memtoreg 0.
REQ-016 ADDIEX and ADDIWR SHALL drive alusrca 1, alusrcb 10, alucont add; ADDIWR adds regwrite 1, regdst 0, memtoreg 0.
REQ-017 BEQEX SHALL drive alusrca 1, alusrcb 00, alucont sub, pcsource 01, branch 1.
REQ-018 JEX SHALL drive pcsource 10, pcwrite 1.
REQ-019 pcen SHALL equal pcwrite OR (branch AND zero), combinational on zero in the same cycle.
REQ-020 alucont encoding SHALL be add 010, sub 110, and 000, or 001, slt 111.
REQ-021 funct decode SHALL map 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct -> add.
REQ-022 Unlisted controls SHALL be 0 in every state; latency: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6 cycles.

Reset
REQ-023 reset high at a rising clk edge SHALL load FETCH1, overriding any transition, including mid-instruction.
REQ-024 While reset is high, pcen, memwrite, regwrite, irwrite SHALL be forced 0; other outputs SHALL take FETCH1 values.
REQ-025 First cycle after reset deassertion SHALL execute FETCH1 with irwrite 0001, pcen 1.

Structure
REQ-026 Shared package SHALL hold state encoding (4-bit), opcode constants, funct constants, alucont codes.
REQ-027 funct/aluop->alucont decode SHALL be sub-module alu_decoder (inputs aluop[1:0], funct; output alucont).
REQ-028 State register SHALL be the only sequential element; all outputs combinational from state plus zero.

Verification
REQ-029 reset 2 cycles then release, op 000000 funct 100101 -> irwrite 0001,0010,0100,1000 over 4 cycles, DECODE, RTYPEEX alucont 001, RTYPEWR regwrite 1 regdst 1, then FETCH1.
REQ-030 op 100000 -> MEMADR, LBRD iord 1, LBWR regwrite 1 memtoreg 1; total 8 cycles back to FETCH1.
REQ-031 op 000100 with zero 1 in BEQEX -> pcen 1 pcsource 01; repeat with zero 0 -> pcen 0.
REQ-032 op 101000 -> SBWR memwrite 1 iord 1 for exactly one cycle; op 000010 -> JEX pcen 1 pcsource 10.
REQ-033 op 111111 in DECODE -> next state FETCH1, no write enables asserted.
REQ-034 reset asserted during SBWR -> memwrite 0 that cycle, FETCH1 next cycle; funct 000111 -> alucont 010.
